// File: rtl/pcs_block_lock.sv
// ============================================================================
// Module   : pcs_block_lock
// Brief    : 64b/66b sync-header block-lock engine with rxslip hunting and a
//            registered, lock-gated RX data/header pass-through.
//            Optional statistics counters: define PCS_BLOCK_LOCK_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcs_block_lock #(
    parameter int DATA_WIDTH       = 64,
    parameter int LOCK_GOOD_COUNT  = 64,
    parameter int WINDOW_LEN       = 64,
    parameter int BAD_LIMIT        = 16,
    parameter int SLIP_WAIT_CYCLES = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_reset_done,
    input  logic [DATA_WIDTH-1:0] i_rxdata,
    input  logic                  i_rxdatavalid,
    input  logic [1:0]            i_rxheader,
    input  logic                  i_rxheader_valid,
    output logic                  o_rxslip,
    output logic                  o_block_lock,
    output logic [DATA_WIDTH-1:0] o_rxdata,
    output logic                  o_rxdatavalid,
    output logic [1:0]            o_rxheader,
    output logic                  o_rxheader_valid
`ifdef PCS_BLOCK_LOCK_STATS_EN
    ,
    output logic [15:0]           o_slip_count,
    output logic [15:0]           o_lock_loss_count
`endif
);

    localparam int GW = $clog2(LOCK_GOOD_COUNT + 1);
    localparam int NW = $clog2(WINDOW_LEN + 1);
    localparam int BW = $clog2(BAD_LIMIT + 1);
    localparam int WW = $clog2(SLIP_WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP      = 2'd1,
        ST_SLIP_WAIT = 2'd2,
        ST_LOCKED    = 2'd3
    } state_t;

    state_t                state_q;
    logic [GW-1:0]         good_cnt_q;
    logic [NW-1:0]         win_cnt_q;
    logic [BW-1:0]         bad_cnt_q;
    logic [WW-1:0]         wait_cnt_q;
    logic                  rxslip_q;
    logic                  block_lock_q;
    logic [DATA_WIDTH-1:0] rxdata_q;
    logic                  rxdatavalid_q;
    logic [1:0]            rxheader_q;
    logic                  rxheader_valid_q;

    logic                  hdr_bad;
    logic [NW-1:0]         win_cnt_d;
    logic [BW-1:0]         bad_cnt_d;

    // Valid sync headers are 01 and 10, i.e. exactly the ones with odd parity.
    assign hdr_bad   = ~(^i_rxheader);
    assign win_cnt_d = win_cnt_q + NW'(1);
    assign bad_cnt_d = bad_cnt_q + BW'(hdr_bad);

`ifdef PCS_BLOCK_LOCK_STATS_EN
    logic [15:0] slip_count_q;
    logic [15:0] lock_loss_count_q;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q          <= ST_SEARCH;
            good_cnt_q       <= '0;
            win_cnt_q        <= '0;
            bad_cnt_q        <= '0;
            wait_cnt_q       <= '0;
            rxslip_q         <= 1'b0;
            block_lock_q     <= 1'b0;
            rxdata_q         <= '0;
            rxdatavalid_q    <= 1'b0;
            rxheader_q       <= 2'b00;
            rxheader_valid_q <= 1'b0;
`ifdef PCS_BLOCK_LOCK_STATS_EN
            slip_count_q      <= '0;
            lock_loss_count_q <= '0;
`endif
        end else begin
            // Valids use the lock flag of this cycle, so the completing header is
            // dropped and the header that breaks lock still goes through.
            rxdata_q         <= i_rxdata;
            rxheader_q       <= i_rxheader;
            rxdatavalid_q    <= i_rxdatavalid & block_lock_q;
            rxheader_valid_q <= i_rxheader_valid & block_lock_q;
            rxslip_q         <= 1'b0;
`ifdef PCS_BLOCK_LOCK_STATS_EN
            if (rxslip_q && (slip_count_q != 16'hFFFF))
                slip_count_q <= slip_count_q + 16'd1;
`endif
            if (!i_rx_reset_done) begin
                state_q      <= ST_SEARCH;
                good_cnt_q   <= '0;
                win_cnt_q    <= '0;
                bad_cnt_q    <= '0;
                wait_cnt_q   <= '0;
                block_lock_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_SEARCH: begin
                        if (i_rxheader_valid) begin
                            if (hdr_bad) begin
                                good_cnt_q <= '0;
                                rxslip_q   <= 1'b1;
                                state_q    <= ST_SLIP;
                            end else if (good_cnt_q == GW'(LOCK_GOOD_COUNT - 1)) begin
                                good_cnt_q   <= '0;
                                block_lock_q <= 1'b1;
                                state_q      <= ST_LOCKED;
                            end else begin
                                good_cnt_q <= good_cnt_q + GW'(1);
                            end
                        end
                    end
                    ST_SLIP: begin
                        wait_cnt_q <= '0;
                        state_q    <= ST_SLIP_WAIT;
                    end
                    ST_SLIP_WAIT: begin
                        if (wait_cnt_q == WW'(SLIP_WAIT_CYCLES - 1)) begin
                            wait_cnt_q <= '0;
                            good_cnt_q <= '0;
                            state_q    <= ST_SEARCH;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + WW'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (i_rxheader_valid) begin
                            // Lock loss is tested first so it wins over a window end.
                            if (bad_cnt_d == BW'(BAD_LIMIT)) begin
                                win_cnt_q    <= '0;
                                bad_cnt_q    <= '0;
                                block_lock_q <= 1'b0;
                                rxslip_q     <= 1'b1;
                                state_q      <= ST_SLIP;
`ifdef PCS_BLOCK_LOCK_STATS_EN
                                if (lock_loss_count_q != 16'hFFFF)
                                    lock_loss_count_q <= lock_loss_count_q + 16'd1;
`endif
                            end else if (win_cnt_d == NW'(WINDOW_LEN)) begin
                                win_cnt_q <= '0;
                                bad_cnt_q <= '0;
                            end else begin
                                win_cnt_q <= win_cnt_d;
                                bad_cnt_q <= bad_cnt_d;
                            end
                        end
                    end
                    default: state_q <= ST_SEARCH;
                endcase
            end
        end
    end

    assign o_rxslip         = rxslip_q;
    assign o_block_lock     = block_lock_q;
    assign o_rxdata         = rxdata_q;
    assign o_rxdatavalid    = rxdatavalid_q;
    assign o_rxheader       = rxheader_q;
    assign o_rxheader_valid = rxheader_valid_q;
`ifdef PCS_BLOCK_LOCK_STATS_EN
    assign o_slip_count      = slip_count_q;
    assign o_lock_loss_count = lock_loss_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pcs_block_lock.sv
// ============================================================================
// Module   : tb_pcs_block_lock
// Brief    : Directed self-checking bench for pcs_block_lock (lock acquisition,
//            slip spacing, window/bad-limit behaviour, reset_done re-hunt, stats).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcs_block_lock;

`ifdef PCS_BLOCK_LOCK_STATS_EN
    localparam int DW = 32;
`else
    localparam int DW = 64;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_rx_reset_done = 1'b0;
    logic [DW-1:0] i_rxdata = '0;
    logic          i_rxdatavalid = 1'b0;
    logic [1:0]    i_rxheader = 2'b00;
    logic          i_rxheader_valid = 1'b0;
    logic          o_rxslip;
    logic          o_block_lock;
    logic [DW-1:0] o_rxdata;
    logic          o_rxdatavalid;
    logic [1:0]    o_rxheader;
    logic          o_rxheader_valid;
`ifdef PCS_BLOCK_LOCK_STATS_EN
    logic [15:0]   o_slip_count;
    logic [15:0]   o_lock_loss_count;
`endif

    int            checks = 0;
    int            errors = 0;
    int            slips  = 0;
    int            s0;
    logic [DW-1:0] last_data;

    pcs_block_lock #(.DATA_WIDTH(DW)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_rx_reset_done  (i_rx_reset_done),
        .i_rxdata         (i_rxdata),
        .i_rxdatavalid    (i_rxdatavalid),
        .i_rxheader       (i_rxheader),
        .i_rxheader_valid (i_rxheader_valid),
        .o_rxslip         (o_rxslip),
        .o_block_lock     (o_block_lock),
        .o_rxdata         (o_rxdata),
        .o_rxdatavalid    (o_rxdatavalid),
        .o_rxheader       (o_rxheader),
        .o_rxheader_valid (o_rxheader_valid)
`ifdef PCS_BLOCK_LOCK_STATS_EN
        ,
        .o_slip_count      (o_slip_count),
        .o_lock_loss_count (o_lock_loss_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One header beat: drive, clock, then sample 1 ns after the edge.
    task automatic send(input logic [1:0] h);
        logic [63:0] r;
        r                = {$urandom, $urandom};
        i_rxheader       = h;
        i_rxheader_valid = 1'b1;
        i_rxdatavalid    = 1'b1;
        i_rxdata         = r[DW-1:0];
        last_data        = r[DW-1:0];
        @(posedge i_clk);
        #1;
        if (o_rxslip) slips++;
    endtask

    task automatic sendn(input logic [1:0] h, input int n);
        for (int k = 0; k < n; k++) send(h);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_lock", 64'(o_block_lock), 64'd0);
        chk("rst_slip", 64'(o_rxslip), 64'd0);
        chk("rst_hv", 64'(o_rxheader_valid), 64'd0);
        chk("rst_dv", 64'(o_rxdatavalid), 64'd0);
        chk("rst_data", 64'(o_rxdata), 64'd0);
        i_rst = 1'b0;
        i_rx_reset_done = 1'b1;
        @(posedge i_clk);
        #1;

        // 1: 64 good headers -> lock the cycle after the 64th
        sendn(2'b01, 63);
        chk("t1_lock_63", 64'(o_block_lock), 64'd0);
        send(2'b01);
        chk("t1_lock_64", 64'(o_block_lock), 64'd1);
        chk("t1_first_not_fwd", 64'(o_rxheader_valid), 64'd0);
        chk("t1_no_slip", 64'(slips), 64'd0);
        send(2'b10);
        chk("t1_fwd_hv", 64'(o_rxheader_valid), 64'd1);
        chk("t1_fwd_dv", 64'(o_rxdatavalid), 64'd1);
        chk("t1_fwd_data", 64'(o_rxdata), 64'(last_data));
        chk("t1_fwd_hdr", 64'(o_rxheader), 64'd2);

        // 3: window with 15 bad survives (one header already in this window)
        sendn(2'b11, 15);
        sendn(2'b01, 48);
        chk("t3_win_keep", 64'(o_block_lock), 64'd1);
        sendn(2'b00, 15);
        chk("t3_15bad_keep", 64'(o_block_lock), 64'd1);
        send(2'b11);
        chk("t3_16bad_drop", 64'(o_block_lock), 64'd0);
        chk("t3_drop_slip", 64'(o_rxslip), 64'd1);
        chk("t3_loss_fwd_hv", 64'(o_rxheader_valid), 64'd1);
        chk("t3_loss_fwd_hdr", 64'(o_rxheader), 64'd3);

        // Headers during SLIP + SLIP_WAIT are ignored; next slip exactly 34 cycles later
        s0 = slips;
        sendn(2'b11, 33);
        chk("wait_no_slip", 64'(slips - s0), 64'd0);
        chk("wait_no_fwd", 64'(o_rxheader_valid), 64'd0);
        send(2'b11);
        chk("wait_spacing_slip", 64'(o_rxslip), 64'd1);

        // 2: 10 good then a bad header -> slip; ignored headers must not count
        sendn(2'b01, 33);
        sendn(2'b01, 10);
        chk("t2_10good_nolock", 64'(o_block_lock), 64'd0);
        send(2'b11);
        chk("t2_bad_slip", 64'(o_rxslip), 64'd1);
        send(2'b01);
        chk("t2_slip_one_cycle", 64'(o_rxslip), 64'd0);
        sendn(2'b01, 32);
        sendn(2'b10, 63);
        chk("t2_relock_63", 64'(o_block_lock), 64'd0);
        send(2'b10);
        chk("t2_relock_64", 64'(o_block_lock), 64'd1);

        // 4: 64th header of a window is the 16th bad -> lock loss wins
        sendn(2'b00, 15);
        sendn(2'b01, 48);
        chk("t4_63_keep", 64'(o_block_lock), 64'd1);
        send(2'b00);
        chk("t4_drop", 64'(o_block_lock), 64'd0);
        chk("t4_slip", 64'(o_rxslip), 64'd1);

        // 5a: reset_done drop during SLIP_WAIT -> straight back to SEARCH
        sendn(2'b01, 5);
        i_rx_reset_done = 1'b0;
        send(2'b01);
        chk("t5a_lock", 64'(o_block_lock), 64'd0);
        chk("t5a_slip", 64'(o_rxslip), 64'd0);
        i_rx_reset_done = 1'b1;
        s0 = slips;
        sendn(2'b01, 63);
        chk("t5a_relock_63", 64'(o_block_lock), 64'd0);
        send(2'b01);
        chk("t5a_relock_64", 64'(o_block_lock), 64'd1);
        chk("t5a_no_slip", 64'(slips - s0), 64'd0);

        // 5b: reset_done drop while LOCKED
        sendn(2'b01, 3);
        i_rx_reset_done = 1'b0;
        send(2'b01);
        chk("t5b_lock", 64'(o_block_lock), 64'd0);
        chk("t5b_last_fwd", 64'(o_rxheader_valid), 64'd1);
        i_rx_reset_done = 1'b1;
        send(2'b01);
        chk("t5b_no_fwd", 64'(o_rxdatavalid), 64'd0);
        chk("t5b_data_passes", 64'(o_rxdata), 64'(last_data));
        sendn(2'b01, 62);
        chk("t5b_relock_63", 64'(o_block_lock), 64'd0);
        send(2'b01);
        chk("t5b_relock_64", 64'(o_block_lock), 64'd1);
        send(2'b10);
        chk("t5b_fwd_data", 64'(o_rxdata), 64'(last_data));
        chk("t5b_fwd_dv", 64'(o_rxdatavalid), 64'd1);

`ifdef PCS_BLOCK_LOCK_STATS_EN
        // 6: four slip pulses, two of them from lock loss; reset_done does not clear
        chk("t6_slip_count", 64'(o_slip_count), 64'd4);
        chk("t6_lock_loss_count", 64'(o_lock_loss_count), 64'd2);
`endif
        chk("total_slips", 64'(slips), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
